// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback driver for the RV32I core.
// Extracts and extends load data, masks x0 and reserved writes, and counts retired instructions.
module wb_stage #(
    parameter int Data_width = 32,
    parameter int Cnt_width  = 64
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [4:0]            mem_rd_add,
    input  logic [1:0]            mem_wb_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [Data_width-1:0] mem_alu_result,
    input  logic [Data_width-1:0] mem_load_data,
    input  logic [Data_width-1:0] mem_pc_plus4,
    output logic                  write,
    output logic [4:0]            dest_add,
    output logic [Data_width-1:0] dest_data,
    output logic                  wb_valid,
    output logic                  load_err,
    output logic [Cnt_width-1:0]  retired
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [4:0]            rd;
        logic [1:0]            wb_sel;
        logic [2:0]            funct3;
        logic [Data_width-1:0] alu_result;
        logic [Data_width-1:0] load_data;
        logic [Data_width-1:0] pc_plus4;
    } wb_reg_t;

    wb_reg_t wb_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the WB register is a handful of flops, not a memory, so the whole thing is cleared on reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q.valid <= 1'b0;
        end else if (!stall) begin
            wb_q.valid      <= mem_valid;
            wb_q.reg_write  <= mem_reg_write;
            wb_q.rd         <= mem_rd_add;
            wb_q.wb_sel     <= mem_wb_sel;
            wb_q.funct3     <= mem_funct3;
            wb_q.alu_result <= mem_alu_result;
            wb_q.load_data  <= mem_load_data;
            wb_q.pc_plus4   <= mem_pc_plus4;
        end
    end

    // A flushed or stalled instruction has not left WB yet, so it is not counted.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            retired <= '0;
        end else if (wb_q.valid && !stall && !flush) begin
            retired <= retired + {{(Cnt_width-1){1'b0}}, 1'b1};
        end
    end

    logic [1:0]            off;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [Data_width-1:0] load_val;
    logic                  bad_funct3;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        off        = wb_q.alu_result[1:0];
        lane_byte  = 8'h00;
        lane_half  = off[1] ? wb_q.load_data[31:16] : wb_q.load_data[15:0];
        load_val   = wb_q.load_data;
        bad_funct3 = 1'b0;

        case (off)
            2'd0:    lane_byte = wb_q.load_data[7:0];
            2'd1:    lane_byte = wb_q.load_data[15:8];
            2'd2:    lane_byte = wb_q.load_data[23:16];
            default: lane_byte = wb_q.load_data[31:24];
        endcase

        case (wb_q.funct3)
            F3_LB:   load_val = {{(Data_width-8){lane_byte[7]}}, lane_byte};
            F3_LBU:  load_val = {{(Data_width-8){1'b0}}, lane_byte};
            F3_LH:   load_val = {{(Data_width-16){lane_half[15]}}, lane_half};
            F3_LHU:  load_val = {{(Data_width-16){1'b0}}, lane_half};
            F3_LW:   load_val = wb_q.load_data;
            default: begin
                load_val   = wb_q.load_data;
                bad_funct3 = 1'b1;
            end
        endcase
    end

    always_comb begin
        dest_data = '0;
        case (wb_q.wb_sel)
            SEL_ALU:  dest_data = wb_q.alu_result;
            SEL_LOAD: dest_data = load_val;
            SEL_PC4:  dest_data = wb_q.pc_plus4;
            default:  dest_data = '0;
        endcase
    end

    assign dest_add = wb_q.rd;
    assign wb_valid = wb_q.valid;
    assign load_err = wb_q.valid && (wb_q.wb_sel == SEL_LOAD) && bad_funct3;
    assign write    = wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0)
                      && (wb_q.wb_sel != SEL_RSVD) && !load_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: behavioural model compared every cycle, plus literal directed checks.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd_add = '0;
    logic [1:0]  mem_wb_sel = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_load_data = '0;
    logic [31:0] mem_pc_plus4 = '0;

    logic        write, wb_valid, load_err;
    logic [4:0]  dest_add;
    logic [31:0] dest_data;
    logic [63:0] retired;

    logic        write4, wb_valid4, load_err4;
    logic [4:0]  dest_add4;
    logic [31:0] dest_data4;
    logic [3:0]  retired4;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 Clk = ~Clk;

    wb_stage #(.Data_width(32), .Cnt_width(64)) u_dut (
        .Clk(Clk), .Rst(Rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_add(mem_rd_add),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .write(write), .dest_add(dest_add), .dest_data(dest_data),
        .wb_valid(wb_valid), .load_err(load_err), .retired(retired)
    );

    wb_stage #(.Data_width(32), .Cnt_width(4)) u_dut4 (
        .Clk(Clk), .Rst(Rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_add(mem_rd_add),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .write(write4), .dest_add(dest_add4), .dest_data(dest_data4),
        .wb_valid(wb_valid4), .load_err(load_err4), .retired(retired4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        valid;
        bit        rw;
        bit [4:0]  rd;
        bit [1:0]  sel;
        bit [2:0]  f3;
        bit [31:0] alu;
        bit [31:0] ld;
        bit [31:0] pc4;
    } instr_t;

    instr_t          m_wb;
    longint unsigned m_ret;

    function automatic bit is_bad_load(instr_t w);
        return w.valid && w.sel == 2'd1 && (w.f3 == 3'd3 || w.f3 == 3'd6 || w.f3 == 3'd7);
    endfunction

    function automatic bit [31:0] model_data(instr_t w);
        int unsigned off, b, h;
        off = w.alu % 4;
        b   = (w.ld >> (8 * off)) & 32'hFF;
        h   = (w.ld >> (16 * (off / 2))) & 32'hFFFF;
        case (w.sel)
            2'd0: return w.alu;
            2'd2: return w.pc4;
            2'd3: return 32'd0;
            default: begin
                case (w.f3)
                    3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
                    3'd4:    return b;
                    3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd5:    return h;
                    default: return w.ld;
                endcase
            end
        endcase
    endfunction

    function automatic bit model_write(instr_t w);
        return w.valid && w.rw && w.rd != 0 && w.sel != 2'd3 && !is_bad_load(w);
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_wb  = '{default: 0};
            m_ret = 0;
        end else begin
            if (m_wb.valid && !stall && !flush) m_ret = m_ret + 1;
            if (flush) m_wb.valid = 1'b0;
            else if (!stall)
                m_wb = '{mem_valid, mem_reg_write, mem_rd_add, mem_wb_sel, mem_funct3,
                         mem_alu_result, mem_load_data, mem_pc_plus4};
        end
    end

    // Compare process: outputs depend only on the WB register, so sample on the falling edge.
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("write",     write,     model_write(m_wb));
            check("wb_valid",  wb_valid,  m_wb.valid);
            check("load_err",  load_err,  is_bad_load(m_wb));
            check("dest_add",  dest_add,  m_wb.rd);
            check("dest_data", dest_data, model_data(m_wb));
            check("retired",   retired,   m_ret);
            check("retired4",  retired4,  m_ret % 16);
            check("write4",    write4,    model_write(m_wb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] sel,
                         input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] ld,
                         input bit [31:0] pc4);
        mem_valid = v; mem_reg_write = rw; mem_rd_add = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc4;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] exp;
    } load_case_t;

    load_case_t loads[5] = '{
        '{3'd0, 32'h1000, 32'hFFFFFFA5},
        '{3'd4, 32'h1001, 32'h000000F0},
        '{3'd1, 32'h1002, 32'hFFFF8070},
        '{3'd5, 32'h1000, 32'h0000F0A5},
        '{3'd2, 32'h1003, 32'h8070F0A5}
    };

    longint unsigned r0;

    initial begin
        repeat (2) @(negedge Clk);
        check("rst_write", write, 0);
        check("rst_data", dest_data, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_retired", retired, 0);
        Rst = 1'b0;
        cmp_en = 1'b1;

        // ALU path
        drive(1, 1, 5, 2'd0, 0, 32'hDEADBEEF, 0, 0);
        @(negedge Clk);
        check("alu_write", write, 1);
        check("alu_add", dest_add, 5);
        check("alu_data", dest_data, 32'hDEADBEEF);
        check("alu_retired_before", retired, 0);
        bubble();
        @(negedge Clk);
        check("alu_retired_after", retired, 1);

        // Load extraction
        foreach (loads[i]) begin
            drive(1, 1, 3, 2'd1, loads[i].f3, loads[i].addr, 32'h8070F0A5, 0);
            @(negedge Clk);
            check($sformatf("load%0d_data", i), dest_data, loads[i].exp);
            check($sformatf("load%0d_write", i), write, 1);
        end

        // x0, reserved select, bad funct3
        drive(1, 1, 0, 2'd0, 0, 7, 0, 0);
        @(negedge Clk);
        check("x0_write", write, 0);
        r0 = retired;
        drive(1, 1, 4, 2'd3, 0, 32'h55, 0, 32'h66);
        @(negedge Clk);
        check("x0_retired", retired, r0 + 1);
        check("rsvd_write", write, 0);
        check("rsvd_data", dest_data, 0);
        drive(1, 1, 4, 2'd1, 3'd6, 0, 32'h12345678, 0);
        @(negedge Clk);
        check("badld_err", load_err, 1);
        check("badld_write", write, 0);

        // Stall on JAL for 3 cycles
        drive(1, 1, 1, 2'd2, 0, 0, 0, 32'h104);
        @(negedge Clk);
        r0 = retired;
        stall = 1'b1;
        drive(1, 1, 9, 2'd0, 0, 32'hBAD, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("stall_write", write, 1);
            check("stall_data", dest_data, 32'h104);
            check("stall_retired", retired, r0);
        end
        stall = 1'b0;
        bubble();
        @(negedge Clk);
        check("unstall_retired", retired, r0 + 1);
        check("unstall_write", write, 0);

        // Flush together with stall
        drive(1, 1, 2, 2'd0, 0, 32'h22, 0, 0);
        @(negedge Clk);
        r0 = retired;
        stall = 1'b1;
        flush = 1'b1;
        @(negedge Clk);
        check("flush_valid", wb_valid, 0);
        check("flush_write", write, 0);
        check("flush_retired", retired, r0);
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset between edges
        drive(1, 1, 7, 2'd0, 0, 32'hCAFE, 0, 0);
        @(negedge Clk);
        check("pre_rst_write", write, 1);
        #2 Rst = 1'b1;
        #1;
        check("midrst_write", write, 0);
        check("midrst_data", dest_data, 0);
        check("midrst_retired", retired, 0);
        #1 Rst = 1'b0;

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 6, 2'd0, 0, i, 0, 0);
            @(negedge Clk);
        end
        check("wrap_pre", retired4, 15);
        bubble();
        @(negedge Clk);
        check("wrap_retired4", retired4, 0);
        check("wrap_retired64", retired, 16);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            @(negedge Clk);
        end
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        @(negedge Clk);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core.
- It is the write-side driver of the register file: it produces write, dest_add and dest_data from MEM-stage results.
- Performs load-data byte/halfword extraction with sign/zero extension.
- Suppresses writes to x0 and counts retired instructions.

Parameters:
- Data_width, 32, datapath width (only 32 supported)
- Cnt_width, 64, width of the retired-instruction counter

Ports:
- Clk  input  1  clock, rising-edge
- Rst  input  1  asynchronous, active-high reset
- stall  input  1  hold the WB register contents
- flush  input  1  insert a bubble into WB
- mem_valid  input  1  MEM stage holds a real instruction
- mem_reg_write  input  1  instruction writes rd
- mem_rd_add  input  5  destination register index
- mem_wb_sel  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved
- mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_alu_result  input  Data_width  ALU result or load address
- mem_load_data  input  Data_width  raw aligned word from data memory
- mem_pc_plus4  input  Data_width  link value
- write  output  1  register-file write enable
- dest_add  output  5  register-file write index
- dest_data  output  Data_width  register-file write data
- wb_valid  output  1  WB holds a real instruction
- load_err  output  1  WB holds a load with undefined funct3
- retired  output  Cnt_width  retired-instruction count

Behaviour:
- WB register fields: valid, reg_write, rd, wb_sel, funct3, alu_result, load_data, pc_plus4.
- Rst asserted, at any time including mid-operation: all fields and retired clear to 0 immediately, no clock required.
  - Outputs during reset: write=0, dest_add=0, dest_data=0, wb_valid=0, load_err=0.
- Register update at posedge Clk, priority order:
  - flush=1: valid<=0; other fields don't-care but keep their values. Flush wins over stall.
  - else stall=1: all fields hold.
  - else: all fields load from the mem_* inputs.
- Latency: mem_* inputs sampled at edge N appear on write/dest_add/dest_data after edge N. Outputs are combinational from the WB register only; no input-to-output combinational path.
- dest_add = rd; wb_valid = valid.
- dest_data by wb_sel:
  - 00: alu_result.
  - 10: pc_plus4.
  - 11: 0.
  - 01: load extraction with off = alu_result[1:0]:
    - LB/LBU: byte lane off, i.e. load_data[8*off+7 : 8*off], sign/zero-extended.
    - LH/LHU: halfword lane off[1], load_data[16*off[1]+15 : 16*off[1]]; off[0] ignored.
    - LW: load_data; off ignored.
    - funct3 011/110/111: dest_data = load_data.
- load_err = valid & wb_sel==01 & funct3 in {011,110,111}.
- write = valid & reg_write & (rd != 0) & (wb_sel != 11) & !load_err.
- write is level-held for every cycle WB holds the instruction, including stall cycles; repeated identical writes are harmless.
- retired increments by 1 at posedge when valid=1 & stall=0 & flush=0. It counts instructions with reg_write=0 and with load_err.
  - Wraps from 2^Cnt_width-1 to 0.
  - A flushed instruction is not counted.
- Simultaneous flush and stall: bubble is inserted and retired does not increment.

Test Plan:
- Reset mid-stream: with valid=1 and write=1, assert Rst between clock edges -> write=0, dest_data=0, retired=0 before the next edge.
- ALU path: mem_valid=1, reg_write=1, rd=5, wb_sel=00, alu_result=0xDEADBEEF -> next cycle write=1, dest_add=5, dest_data=0xDEADBEEF; retired increments by 1 at the following edge.
- Loads from load_data=0x8070F0A5:
  - LB off=0 -> 0xFFFFFFA5.
  - LBU off=1 -> 0x000000F0.
  - LH off=2 -> 0xFFFF8070.
  - LHU off=0 -> 0x0000F0A5.
  - LW off=3 -> 0x8070F0A5.
- x0 and reserved cases:
  - rd=0, reg_write=1, alu_result=7 -> write=0, retired still increments.
  - wb_sel=11 -> write=0, dest_data=0.
  - load with funct3=110 -> load_err=1, write=0.
- Stall/flush:
  - Hold stall=1 for 3 cycles on a valid JAL (wb_sel=10, pc_plus4=0x104, rd=1) -> write=1, dest_data=0x104 all 3 cycles; retired +1 only after stall drops.
  - flush=1 together with stall=1 -> wb_valid=0, write=0 next cycle, no increment.
- Counter wrap (Cnt_width=4): retire 16 instructions -> retired returns to 0.
